// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and downstream-side memory handshake signals for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS-1:0]                 req_read;
  logic [NUM_PORTS-1:0]                 req_write;
  logic [NUM_PORTS-1:0][BE_W-1:0]       req_byte_enable;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0]                req_rdata;
  logic [NUM_PORTS-1:0]                 req_resp;

  logic [ADDR_WIDTH-1:0]                mem_address;
  logic                                 mem_read;
  logic                                 mem_write;
  logic [BE_W-1:0]                      mem_byte_enable;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic [DATA_WIDTH-1:0]                mem_rdata;
  logic                                 mem_resp;

  modport slave (
    input  req_address, req_read, req_write, req_byte_enable, req_wdata,
    output req_rdata, req_resp,
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output req_address, req_read, req_write, req_byte_enable, req_wdata,
    input  req_rdata, req_resp,
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-to-1 memory port arbiter: grants one requester, latches and forwards its request, routes the resp back.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_port_arbiter_if.slave            bus,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         busy
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W:0]   NP_W    = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(32'd1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   hold_addr_r;
  logic [BE_W-1:0]         hold_be_r;
  logic [DATA_WIDTH-1:0]   hold_wdata_r;
  logic                    mem_read_r;
  logic                    mem_write_r;
  logic [IDX_W-1:0]        grant_idx_r;
  logic                    busy_r;

  logic [NUM_PORTS-1:0]    pending_s;
  logic [IDX_W-1:0]        rr_ptr_s;
  logic [IDX_W-1:0]        win_s;
  logic                    found_s;
  logic [NUM_PORTS-1:0]    req_resp_s;

  // (base + off) modulo NUM_PORTS; both operands are already below NUM_PORTS
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NP_W) begin
      sum = sum - NP_W;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  assign pending_s = bus.req_read | bus.req_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_r;

  // Round-robin pointer: moves to one past the winner on every grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (state_r == ST_IDLE && found_s) begin
      rr_ptr_r <= rr_index(win_s, IDX_ONE);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign rr_ptr_s = rr_ptr_r;
`else
  assign rr_ptr_s = '0;
`endif

  // Winner search: first pending port at or above the pointer, wrapping to 0
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found_s && pending_s[rr_index(rr_ptr_s, i[IDX_W-1:0])]) begin
        win_s   = rr_index(rr_ptr_s, i[IDX_W-1:0]);
        found_s = 1'b1;
      end else begin
        win_s   = win_s;
        found_s = found_s;
      end
    end
  end

  // Arbitration FSM with holding registers; requester inputs only sampled on the grant edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      hold_addr_r  <= '0;
      hold_be_r    <= '0;
      hold_wdata_r <= '0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      grant_idx_r  <= '0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            hold_addr_r  <= bus.req_address[win_s];
            hold_be_r    <= bus.req_byte_enable[win_s];
            hold_wdata_r <= bus.req_wdata[win_s];
            mem_read_r   <= bus.req_read[win_s];
            mem_write_r  <= bus.req_write[win_s];
            grant_idx_r  <= win_s;
            busy_r       <= 1'b1;
            state_r      <= ST_BUSY;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus.mem_resp) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_BUSY;
          end
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-latency completion pulse routed to the granted port only
  always_comb begin
    req_resp_s = '0;
    if (busy_r && bus.mem_resp) begin
      req_resp_s[grant_idx_r] = 1'b1;
    end else begin
      req_resp_s = '0;
    end
  end

  assign bus.req_resp        = req_resp_s;
  assign bus.req_rdata       = bus.mem_rdata;
  assign bus.mem_address     = hold_addr_r;
  assign bus.mem_byte_enable = hold_be_r;
  assign bus.mem_wdata       = hold_wdata_r;
  assign bus.mem_read        = mem_read_r;
  assign bus.mem_write       = mem_write_r;
  assign grant_idx           = grant_idx_r;
  assign busy                = busy_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with three requester ports.
module tb_mem_port_arbiter;
  localparam int NP = 3;

  logic       clk;
  logic       rst;
  logic [1:0] grant_idx;
  logic       busy;
  int         n_cmp;
  int         n_err;

  mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; returns at the falling edge, away from the active edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.req_read        = '0;
    bus.req_write       = '0;
    bus.req_address     = '0;
    bus.req_byte_enable = '0;
    bus.req_wdata       = '0;
  endtask

  logic [1:0] exp_grant [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    clear_reqs();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h0;
    #12;
    check_val("rst_busy",     {63'd0, busy},          64'd0);
    check_val("rst_mem_read", {63'd0, bus.mem_read},  64'd0);
    check_val("rst_mem_wr",   {63'd0, bus.mem_write}, 64'd0);
    check_val("rst_grant",    {62'd0, grant_idx},     64'd0);
    check_val("rst_mem_addr", {32'd0, bus.mem_address}, 64'd0);
    check_val("rst_resp",     {61'd0, bus.req_resp},  64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single read from port 1, memory answers on the third BUSY cycle
    bus.req_read[1]    = 1'b1;
    bus.req_address[1] = 32'h0000_1000;
    check_val("rd_t_mem_read", {63'd0, bus.mem_read}, 64'd0);
    tick();
    check_val("rd_mem_read",  {63'd0, bus.mem_read},    64'd1);
    check_val("rd_mem_addr",  {32'd0, bus.mem_address}, 64'h1000);
    check_val("rd_grant",     {62'd0, grant_idx},       64'd1);
    check_val("rd_busy",      {63'd0, busy},            64'd1);
    tick();
    check_val("rd_wait_resp", {61'd0, bus.req_resp},    64'd0);
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check_val("rd_resp",  {61'd0, bus.req_resp},  64'b010);
    check_val("rd_rdata", {32'd0, bus.req_rdata}, 64'hDEAD_BEEF);
    tick();
    check_val("rd_after_busy", {63'd0, busy},         64'd0);
    check_val("rd_after_read", {63'd0, bus.mem_read}, 64'd0);
    check_val("rd_idle_addr",  {32'd0, bus.mem_address}, 64'h1000);
    bus.mem_resp = 1'b0;
    clear_reqs();
    tick();

    // Write from port 0 held stable until mem_resp
    bus.req_write[0]       = 1'b1;
    bus.req_address[0]     = 32'h0000_0080;
    bus.req_wdata[0]       = 32'h1234_5678;
    bus.req_byte_enable[0] = 4'b0011;
    tick();
    bus.req_wdata[0]       = 32'hFFFF_FFFF;
    bus.req_byte_enable[0] = 4'b1111;
    check_val("wr_mem_write", {63'd0, bus.mem_write},       64'd1);
    check_val("wr_mem_read",  {63'd0, bus.mem_read},        64'd0);
    check_val("wr_grant",     {62'd0, grant_idx},           64'd0);
    tick();
    check_val("wr_addr",  {32'd0, bus.mem_address},   64'h80);
    check_val("wr_wdata", {32'd0, bus.mem_wdata},     64'h1234_5678);
    check_val("wr_be",    {60'd0, bus.mem_byte_enable}, 64'b0011);
    bus.mem_resp = 1'b1;
    #1;
    check_val("wr_resp", {61'd0, bus.req_resp}, 64'b001);
    tick();
    bus.mem_resp = 1'b0;
    clear_reqs();
    tick();

    // Address change one cycle after grant must not reach the memory side
    bus.req_read[0]    = 1'b1;
    bus.req_address[0] = 32'h0000_0100;
    tick();
    bus.req_address[0] = 32'h0000_0200;
    tick();
    check_val("chg_addr1", {32'd0, bus.mem_address}, 64'h100);
    tick();
    check_val("chg_addr2", {32'd0, bus.mem_address}, 64'h100);
    bus.mem_resp = 1'b1;
    #1;
    check_val("chg_resp", {61'd0, bus.req_resp}, 64'b001);
    tick();
    bus.mem_resp = 1'b0;
    clear_reqs();
    tick();

    // mem_resp while idle produces nothing
    bus.mem_resp = 1'b1;
    #1;
    check_val("idle_resp", {61'd0, bus.req_resp}, 64'd0);
    tick();
    check_val("idle_busy", {63'd0, busy}, 64'd0);
    bus.mem_resp = 1'b0;
    tick();

    // Async reset two cycles into BUSY, between clock edges
    bus.req_read[1]    = 1'b1;
    bus.req_address[1] = 32'h0000_0300;
    tick();
    tick();
    check_val("ar_pre_grant", {62'd0, grant_idx}, 64'd1);
    #2;
    rst          = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    check_val("ar_mem_read", {63'd0, bus.mem_read}, 64'd0);
    check_val("ar_busy",     {63'd0, busy},         64'd0);
    check_val("ar_grant",    {62'd0, grant_idx},    64'd0);
    check_val("ar_resp",     {61'd0, bus.req_resp}, 64'd0);
    clear_reqs();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Contention: ports 0 and 1 request continuously
`ifdef ARB_ROUND_ROBIN_EN
    exp_grant[0] = 2'd0;
    exp_grant[1] = 2'd1;
    exp_grant[2] = 2'd0;
    exp_grant[3] = 2'd1;
`else
    exp_grant[0] = 2'd0;
    exp_grant[1] = 2'd0;
    exp_grant[2] = 2'd0;
    exp_grant[3] = 2'd0;
`endif
    bus.req_read[0]    = 1'b1;
    bus.req_read[1]    = 1'b1;
    bus.req_address[0] = 32'h0000_0400;
    bus.req_address[1] = 32'h0000_0500;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("ct_grant%0d", k), {62'd0, grant_idx}, {62'd0, exp_grant[k]});
      check_val($sformatf("ct_addr%0d", k), {32'd0, bus.mem_address},
                (exp_grant[k] == 2'd0) ? 64'h400 : 64'h500);
      bus.mem_resp = 1'b1;
      #1;
      check_val($sformatf("ct_resp%0d", k), {61'd0, bus.req_resp},
                64'd1 << exp_grant[k]);
      tick();
      bus.mem_resp = 1'b0;
      check_val($sformatf("ct_idle%0d", k), {63'd0, busy}, 64'd0);
    end
    clear_reqs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
